// File: rtl/ps2_scan_decoder.sv
// Turns a raw PS/2 Set-2 scancode byte stream into make/break key events with live modifier state.
// An event appears one cycle after its last byte; in_ready drops only while a held event is not taken.
module ps2_scan_decoder #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
    parameter logic [2:0]  E1_SKIP        = 3'd7
) (
    input  logic       cclk,
    input  logic       cclk_rst_b,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [4:0] mods,
    output logic       err_pulse
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0,
        S_SKIP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_skip, w_skip_nxt;
    logic [23:0] r_tmo, w_tmo_nxt;
    logic        r_err, w_err;
    logic        r_evt_vld;
    logic [7:0]  r_evt_code;
    logic        r_evt_ext, r_evt_brk;
    logic        w_acc, w_fake, w_emit, w_emit_ext, w_emit_brk, w_make;

    logic r_lsh, r_rsh, r_lctrl, r_rctrl, r_lalt, r_ralt;
    logic r_caps_held, r_caps_lock, r_num_held, r_num_lock;

    assign in_ready  = !r_evt_vld || evt_ready;
    assign w_acc     = in_valid && in_ready;
    // E0 12 / E0 59 are synthetic shift codes wrapped around some extended keys
    assign w_fake    = (in_data == 8'h12) || (in_data == 8'h59);
    assign w_make    = !w_emit_brk;

    assign evt_valid = r_evt_vld;
    assign evt_code  = r_evt_code;
    assign evt_ext   = r_evt_ext;
    assign evt_break = r_evt_brk;
    assign err_pulse = r_err;
    assign mods      = {r_caps_lock, r_lalt | r_ralt, r_lctrl | r_rctrl, r_lsh | r_rsh, r_num_lock};

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip;
        w_tmo_nxt   = '0;
        w_err       = 1'b0;
        w_emit      = 1'b0;
        w_emit_ext  = 1'b0;
        w_emit_brk  = 1'b0;
        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    case (in_data)
                        8'hE0: w_state_nxt = S_E0;
                        8'hF0: w_state_nxt = S_F0;
                        8'hE1: begin
                            w_state_nxt = (E1_SKIP == 3'd0) ? S_IDLE : S_SKIP;
                            w_skip_nxt  = E1_SKIP;
                        end
                        8'h00, 8'hFF: w_err = 1'b1;
                        8'hAA, 8'hFA, 8'hFE, 8'hEE: ;
                        default: w_emit = 1'b1;
                    endcase
                end
                S_E0: begin
                    if (in_data == 8'hF0) begin
                        w_state_nxt = S_E0F0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_emit      = !w_fake;
                        w_emit_ext  = 1'b1;
                    end
                end
                S_F0: begin
                    w_state_nxt = S_IDLE;
                    w_emit      = 1'b1;
                    w_emit_brk  = 1'b1;
                end
                S_E0F0: begin
                    w_state_nxt = S_IDLE;
                    w_emit      = !w_fake;
                    w_emit_ext  = 1'b1;
                    w_emit_brk  = 1'b1;
                end
                S_SKIP: begin
                    w_skip_nxt = r_skip - 3'd1;
                    if (r_skip <= 3'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (r_state != S_IDLE) begin
            if (r_tmo == TIMEOUT_CYCLES - 24'd1) begin
                w_state_nxt = S_IDLE;
                w_err       = 1'b1;
            end else begin
                w_tmo_nxt = r_tmo + 24'd1;
            end
        end
    end

    always_ff @(posedge cclk or negedge cclk_rst_b) begin
        if (!cclk_rst_b) begin
            r_state    <= S_IDLE;
            r_skip     <= '0;
            r_tmo      <= '0;
            r_err      <= 1'b0;
            r_evt_vld  <= 1'b0;
            r_evt_code <= '0;
            r_evt_ext  <= 1'b0;
            r_evt_brk  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_skip  <= w_skip_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err;
            if (w_emit) begin
                r_evt_vld  <= 1'b1;
                r_evt_code <= in_data;
                r_evt_ext  <= w_emit_ext;
                r_evt_brk  <= w_emit_brk;
            end else if (evt_ready) begin
                r_evt_vld <= 1'b0;
            end
        end
    end

    // Held bits track physical keys so lock toggles ignore typematic repeats
    always_ff @(posedge cclk or negedge cclk_rst_b) begin
        if (!cclk_rst_b) begin
            r_lsh       <= 1'b0;
            r_rsh       <= 1'b0;
            r_lctrl     <= 1'b0;
            r_rctrl     <= 1'b0;
            r_lalt      <= 1'b0;
            r_ralt      <= 1'b0;
            r_caps_held <= 1'b0;
            r_caps_lock <= 1'b0;
            r_num_held  <= 1'b0;
            r_num_lock  <= 1'b0;
        end else if (w_emit) begin
            if (!w_emit_ext) begin
                case (in_data)
                    8'h12: r_lsh   <= w_make;
                    8'h59: r_rsh   <= w_make;
                    8'h14: r_lctrl <= w_make;
                    8'h11: r_lalt  <= w_make;
                    8'h77: begin
                        if (w_make && !r_num_held) begin
                            r_num_lock <= ~r_num_lock;
                        end
                        r_num_held <= w_make;
                    end
                    default: ;
                endcase
            end else begin
                case (in_data)
                    8'h14: r_rctrl <= w_make;
                    8'h11: r_ralt  <= w_make;
                    default: ;
                endcase
            end
            if (in_data == 8'h58) begin
                if (w_make && !r_caps_held) begin
                    r_caps_lock <= ~r_caps_lock;
                end
                r_caps_held <= w_make;
            end
        end
    end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Downstream consumer of the PS/2 keyboard receiver's scancode FIFO, in the `cclk` domain.
- Parses raw Set-2 scancode bytes into discrete key events. Each event carries: make/break, extended (E0) flag, base code, and a live modifier/lock state vector.
- Feeds the keyboard SPAM register block and the console driver, so software no longer parses prefixes.

Parameters:
- TIMEOUT_CYCLES, 24'd1000000: `cclk` cycles without a byte while a prefix is pending before the sequence is abandoned.
- E1_SKIP, 3'd7: bytes discarded after an E1 (Pause) lead byte.

Ports:
- cclk  input  1  core clock
- cclk_rst_b  input  1  asynchronous active-low reset
- in_valid  input  1  scancode byte available from FIFO
- in_data  input  8  scancode byte
- in_ready  output  1  byte consumed this cycle when in_valid && in_ready
- evt_valid  output  1  key event held in output register
- evt_ready  input  1  consumer accepts event when evt_valid && evt_ready
- evt_code  output  8  base scancode (prefixes stripped)
- evt_ext  output  1  event was E0-prefixed
- evt_break  output  1  1 = key release, 0 = key press
- mods  output  5  {caps_lock, alt, ctrl, shift, num_lock}, level state
- err_pulse  output  1  one-cycle pulse on timeout or protocol-error byte

Behaviour:
- Reset is asynchronous on cclk_rst_b low. Reset values:
  - state=IDLE
  - evt_valid=0, evt_code=0, evt_ext=0, evt_break=0
  - mods=0, all internal held-key bits=0
  - err_pulse=0, timeout counter=0
- in_ready = !evt_valid || evt_ready. This rule holds in every state, including prefix and skip bytes.
- Byte accepted at edge N → event visible at edge N+1 (evt_valid high). Full throughput is one event per cycle when evt_ready stays high.
- An accepted event clears evt_valid unless a new event loads in the same cycle. Event fields stay stable while evt_valid && !evt_ready.
- FSM states and transitions on accepted byte b:
  - IDLE:
    - b=E0 → E0
    - b=F0 → F0
    - b=E1 → SKIP, load skip counter with E1_SKIP
    - b ∈ {00, FF} → stay IDLE, err_pulse
    - b ∈ {AA, FA, FE, EE} → drop silently, stay IDLE
    - other b → emit make (ext=0, break=0, code=b), stay IDLE
  - E0:
    - b=F0 → E0F0
    - b=12 or 59 (fake shift) → drop, go IDLE
    - other b → emit make ext=1, go IDLE
  - F0: emit break ext=0 code=b, go IDLE.
  - E0F0:
    - b=12 or 59 → drop, go IDLE
    - other b → emit break ext=1, go IDLE
  - SKIP: decrement the counter on each accepted byte. Go IDLE when the count reaches 0. No events are emitted.
- Timeout:
  - Counter is cleared on every accepted byte; it only counts in E0, F0, E0F0 and SKIP.
  - Reaching TIMEOUT_CYCLES-1 → state=IDLE, err_pulse for 1 cycle, counter cleared.
  - If timeout and an accepted byte coincide, the byte wins.
- Modifiers update in the same cycle the event loads into the output register. The emitted event therefore already reflects its own modifier effect.
  - shift = lshift_held | rshift_held. lshift code 12, rshift code 59; both are non-ext.
  - ctrl = lctrl_held | rctrl_held. lctrl is 14 non-ext, rctrl is 14 ext.
  - alt = lalt_held | ralt_held. lalt is 11 non-ext, ralt is 11 ext.
  - caps_lock toggles on make of 58 only if 58 was not already held, so typematic repeat does not toggle.
  - num_lock toggles on make of 77 non-ext only if 77 was not already held.
  - Break of any of these keys clears its held bit.
- Held make codes repeat as events: typematic repeats are not filtered from the event stream.

Test Plan:
- Bytes 1C, F0 1C with evt_ready=1 → two events: {code 1C, ext0, brk0}, then {code 1C, ext0, brk1}. The first has evt_valid 1 cycle after 1C is accepted. No event is emitted for F0.
- E0 F0 75 → single event {code 75, ext1, brk1}. E0 12 E0 7C → single event {code 7C, ext1, brk0}; the fake shift is dropped.
- Sequence 12, 1C, F0 12 → mods.shift=1 on the 12 event and on the 1C event, then 0 on the break event. Sequence 58, 58, F0 58, 58 → caps_lock goes 1, 1, 1, 0.
- E1 14 77 E1 F0 14 F0 77 followed by 29 → only event {code 29}; in_ready stays 1 throughout.
- Hold evt_ready=0 with an event pending, then drive 1C → in_ready=0, evt_code stays stable, and 1C is consumed on the cycle evt_ready rises.
- E0 then idle for TIMEOUT_CYCLES → err_pulse once and state returns to IDLE; a following 1C emits ext=0. A separate check: assert cclk_rst_b mid-E0F0 → all outputs 0, and the next byte 1C emits a non-ext make.
